// File: rtl/gen_switch_sequencer.sv
// gen_switch_sequencer: stalls writes, drains, applies a new PIPE gen/lane config, settles, then acks.
module gen_switch_sequencer #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int DRAIN_TIMEOUT  = 256,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_pd,
  input  logic        linkup,
  input  logic        req,
  input  logic [2:0]  req_gen,
  input  logic [4:0]  req_lanes,
  input  logic        drain_empty,
  output logic        ack,
  output logic        busy,
  output logic [2:0]  gen,
  output logic [4:0]  lanes,
  output logic        sel,
  output logic [63:0] valid,
  output logic        w,
  output logic        timeout_err
);
  localparam int SC = SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES;
  localparam int MX = DRAIN_TIMEOUT > SC ? DRAIN_TIMEOUT : SC;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(SC - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, APPLY, SETTLE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    pgen;
  logic [4:0]    plan;

  function automatic logic [63:0] mask(logic [2:0] g, logic [4:0] l);
    int b, n;
    b = g == 3'd1 ? GEN1_PIPEWIDTH / 8 : g == 3'd2 ? GEN2_PIPEWIDTH / 8 :
        g == 3'd3 ? GEN3_PIPEWIDTH / 8 : g == 3'd4 ? GEN4_PIPEWIDTH / 8 :
        g == 3'd5 ? GEN5_PIPEWIDTH / 8 : 0;
    n = b * (l == 5'd1 ? 1 : l == 5'd2 ? 2 : l == 5'd4 ? 4 : l == 5'd8 ? 8 : 16);
    return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
  endfunction

  assign busy = state != IDLE;
  assign w = valid_pd & linkup & (state == IDLE) & (gen >= 3'd1) & (gen <= 3'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pgen        <= '0;
      plan        <= '0;
      gen         <= '0;
      lanes       <= '0;
      valid       <= '0;
      sel         <= 1'b0;
      ack         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req && linkup) begin
          pgen  <= req_gen;
          plan  <= req_lanes;
          cnt   <= '0;
          state <= DRAIN;
        end
        DRAIN: if (!linkup) state <= IDLE;
          else if (drain_empty) state <= APPLY;
          else if (cnt == DT_LAST) begin
            timeout_err <= 1'b1;
            state       <= APPLY;
          end else cnt <= cnt + 1'b1;
        // the load happens even when linkup drops during this cycle
        APPLY: begin
          gen   <= pgen;
          lanes <= plan;
          valid <= mask(pgen, plan);
          sel   <= pgen >= 3'd3 && pgen <= 3'd5;
          cnt   <= '0;
          state <= linkup ? SETTLE : IDLE;
        end
        SETTLE: if (!linkup) state <= IDLE;
          else if (cnt == SC_LAST) begin
            state <= DONE;
            ack   <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
